// File: rtl/frame_sync_scheduler_pkg.sv
// rtl/frame_sync_scheduler_pkg.sv - shared state and mode encodings for the frame sync scheduler
package frame_sync_scheduler_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARM       = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_SYNC      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  localparam logic [1:0] MODE_FREE   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // The reserved mode behaves exactly like single-trigger, so fold it once at latch time.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/frame_sync_scheduler_if.sv
// rtl/frame_sync_scheduler_if.sv - control, trigger and framer-monitor signals of the scheduler
interface frame_sync_scheduler_if #(
  parameter int CW = 16
);

  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [CW-1:0] burst_len;
  logic [CW-1:0] holdoff;
  logic          trig_in;
  logic          trig_pol;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          ext_sync;
  logic          stream_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] frames_done;
  logic          err;

  modport master (
    output start, abort, mode, burst_len, holdoff, trig_in, trig_pol,
           mon_tvalid, mon_tready, mon_tlast,
    input  ext_sync, stream_en, busy, done, frames_done, err
  );

  modport slave (
    input  start, abort, mode, burst_len, holdoff, trig_in, trig_pol,
           mon_tvalid, mon_tready, mon_tlast,
    output ext_sync, stream_en, busy, done, frames_done, err
  );

endinterface

// File: rtl/frame_trig_edge.sv
// rtl/frame_trig_edge.sv - polarity-selectable trigger edge detector with entry clear
module frame_trig_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic ce_i,
  input  logic trig_i,
  input  logic pol_i,
  input  logic clr_i,
  output logic edge_o
);

  logic prev_q;

  // The sample register tracks the level in every state, so a level already
  // present when the caller starts listening is never seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else if (ce_i) begin
      prev_q <= trig_i;
    end
  end

  assign edge_o = ~clr_i & (pol_i ? (trig_i & ~prev_q) : (~trig_i & prev_q));

endmodule

// File: rtl/frame_sync_scheduler.sv
// rtl/frame_sync_scheduler.sv - acquisition sequencer driving framer sync and stream gating
// Optional watchdog in RUN enabled by FRAME_SYNC_WATCHDOG_EN.
module frame_sync_scheduler
  import frame_sync_scheduler_pkg::*;
#(
  parameter int CW          = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                   clk,
  input logic                   reset_n,
  input logic                   ce,
  frame_sync_scheduler_if.slave bus
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [CW-1:0] holdoff_q, holdoff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] frames_q, frames_d;
  logic          pol_q, pol_d;
  logic          err_q, err_d;

  logic          trig_edge;
  logic          trig_clr;
  logic          frame_hs;
  logic          last_frame;
  logic          arm_done;
  logic [CW-1:0] target;

`ifdef FRAME_SYNC_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  logic [WDW-1:0] wd_q, wd_d;
`else
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  assign frame_hs   = bus.mon_tvalid & bus.mon_tready & bus.mon_tlast;
  assign target     = (burst_q == '0) ? ONE : burst_q;
  assign last_frame = (frames_q == target - ONE);
  assign arm_done   = (holdoff_q == '0) || (cnt_q == holdoff_q - ONE);
  assign trig_clr   = ~((state_q == ST_WAIT_TRIG) || (state_q == ST_RUN));

  frame_trig_edge u_trig_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_i    (ce),
    .trig_i  (bus.trig_in),
    .pol_i   (pol_q),
    .clr_i   (trig_clr),
    .edge_o  (trig_edge)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    burst_d   = burst_q;
    holdoff_d = holdoff_q;
    cnt_d     = cnt_q;
    frames_d  = frames_q;
    pol_d     = pol_q;
    err_d     = err_q;
`ifdef FRAME_SYNC_WATCHDOG_EN
    wd_d      = wd_q;
`endif
    // Abort outranks everything, including a simultaneous start, and keeps the frame count.
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_ARM;
            mode_d    = eff_mode(bus.mode);
            burst_d   = bus.burst_len;
            holdoff_d = bus.holdoff;
            pol_d     = bus.trig_pol;
            cnt_d     = '0;
            frames_d  = '0;
            err_d     = 1'b0;
          end
        end
        ST_ARM: begin
          if (arm_done) begin
            state_d = (mode_q == MODE_FREE) ? ST_SYNC : ST_WAIT_TRIG;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_edge) begin
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          state_d = ST_RUN;
`ifdef FRAME_SYNC_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
        ST_RUN: begin
          if (frame_hs) begin
            frames_d = (&frames_q) ? frames_q : frames_q + ONE;
            if ((mode_q != MODE_FREE) && last_frame) begin
              state_d = ST_DONE;
            end
          end
          // A new trigger while a triggered burst is still running is an overrun.
          if (trig_edge && (mode_q != MODE_FREE)) begin
            err_d = 1'b1;
          end
`ifdef FRAME_SYNC_WATCHDOG_EN
          if (bus.mon_tvalid & bus.mon_tready) begin
            wd_d = '0;
          end else if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
`endif
        end
        ST_DONE: begin
          if (mode_q == MODE_BURST) begin
            state_d  = ST_WAIT_TRIG;
            frames_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_FREE;
      burst_q   <= '0;
      holdoff_q <= '0;
      cnt_q     <= '0;
      frames_q  <= '0;
      pol_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef FRAME_SYNC_WATCHDOG_EN
      wd_q      <= '0;
`endif
    end else if (ce) begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      burst_q   <= burst_d;
      holdoff_q <= holdoff_d;
      cnt_q     <= cnt_d;
      frames_q  <= frames_d;
      pol_q     <= pol_d;
      err_q     <= err_d;
`ifdef FRAME_SYNC_WATCHDOG_EN
      wd_q      <= wd_d;
`endif
    end
  end

  // Pulses are qualified by ce so a frozen SYNC or DONE state emits nothing.
  assign bus.ext_sync    = ce & (state_q == ST_SYNC);
  assign bus.done        = ce & (state_q == ST_DONE);
  assign bus.stream_en   = (state_q == ST_RUN);
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.frames_done = frames_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_frame_sync_scheduler.sv
// tb/tb_frame_sync_scheduler.sv - directed-vector bench for frame_sync_scheduler
module tb_frame_sync_scheduler;

  logic clk;
  logic reset_n;
  logic ce;
  int   n_vec;
  int   n_err;

  frame_sync_scheduler_if #(.CW(16)) bus ();

`ifdef FRAME_SYNC_WATCHDOG_EN
  frame_sync_scheduler #(.CW(16), .TIMEOUT_CYC(16)) dut (
`else
  frame_sync_scheduler #(.CW(16)) dut (
`endif
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: observed timeout, expected completion");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int len);
    for (int i = 0; i < len; i++) begin
      bus.mon_tvalid = 1'b1;
      bus.mon_tready = 1'b1;
      bus.mon_tlast  = (i == len - 1);
      step();
    end
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast  = 1'b0;
  endtask

  // Leaves the DUT in its first ARM cycle, then scrambles the config inputs to prove they were latched.
  task automatic start_acq(input logic [1:0] m, input logic [15:0] bl, input logic [15:0] ho,
                           input logic pol);
    bus.mode      = m;
    bus.burst_len = bl;
    bus.holdoff   = ho;
    bus.trig_pol  = pol;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.burst_len = 16'd0;
    bus.holdoff   = 16'd0;
    bus.trig_pol  = ~pol;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n        = 1'b0;
    ce             = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.mode       = 2'd0;
    bus.burst_len  = 16'd0;
    bus.holdoff    = 16'd0;
    bus.trig_in    = 1'b0;
    bus.trig_pol   = 1'b1;
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast  = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_sen", bus.stream_en, 0);
    chk("rst_sync", bus.ext_sync, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_frames", bus.frames_done, 0);
    chk("rst_err", bus.err, 0);
    reset_n = 1'b1;

    // single trigger, holdoff 4, burst 3, rising edge 10 cycles after start
    start_acq(2'd1, 16'd3, 16'd4, 1'b1);
    chk("m1_arm_busy", bus.busy, 1);
    chk("m1_arm_sen", bus.stream_en, 0);
    repeat (9) step();
    chk("m1_wait_sync", bus.ext_sync, 0);
    bus.trig_in = 1'b1;
    chk("m1_edge_cycle_sync", bus.ext_sync, 0);
    step();
    chk("m1_sync", bus.ext_sync, 1);
    chk("m1_sync_sen", bus.stream_en, 0);
    step();
    chk("m1_run_sync", bus.ext_sync, 0);
    chk("m1_run_sen", bus.stream_en, 1);
    frame(2);
    chk("m1_f1", bus.frames_done, 1);
    frame(3);
    chk("m1_f2", bus.frames_done, 2);
    chk("m1_f2_done", bus.done, 0);
    frame(1);
    chk("m1_done", bus.done, 1);
    chk("m1_done_frames", bus.frames_done, 3);
    chk("m1_done_sen", bus.stream_en, 0);
    chk("m1_done_busy", bus.busy, 0);
    step();
    chk("m1_idle_done", bus.done, 0);
    chk("m1_idle_frames", bus.frames_done, 3);

    // burst-per-trigger, two triggers, auto re-arm
    bus.trig_in = 1'b0;
    start_acq(2'd2, 16'd2, 16'd0, 1'b1);
    step();
    chk("m2_wait_busy", bus.busy, 1);
    chk("m2_wait_frames", bus.frames_done, 0);
    bus.trig_in = 1'b1;
    step();
    chk("m2_sync1", bus.ext_sync, 1);
    step();
    chk("m2_run1_sen", bus.stream_en, 1);
    frame(1);
    chk("m2_f1", bus.frames_done, 1);
    chk("m2_f1_done", bus.done, 0);
    frame(1);
    chk("m2_done1", bus.done, 1);
    chk("m2_done1_frames", bus.frames_done, 2);
    step();
    chk("m2_rearm_frames", bus.frames_done, 0);
    chk("m2_rearm_busy", bus.busy, 1);
    chk("m2_rearm_done", bus.done, 0);
    chk("m2_rearm_sen", bus.stream_en, 0);
    bus.trig_in = 1'b0;
    step();
    bus.trig_in = 1'b1;
    step();
    chk("m2_sync2", bus.ext_sync, 1);
    step();
    frame(2);
    frame(1);
    chk("m2_done2", bus.done, 1);
    chk("m2_done2_frames", bus.frames_done, 2);
    step();
    chk("m2_rearm2_frames", bus.frames_done, 0);
    chk("m2_rearm2_busy", bus.busy, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("m2_abort_busy", bus.busy, 0);

    // trigger overrun during RUN
    bus.trig_in = 1'b0;
    start_acq(2'd1, 16'd2, 16'd1, 1'b1);
    step();
    chk("ovr_err_pre", bus.err, 0);
    bus.trig_in = 1'b1;
    step();
    chk("ovr_sync", bus.ext_sync, 1);
    step();
    bus.trig_in = 1'b0;
    step();
    bus.trig_in = 1'b1;
    step();
    chk("ovr_err", bus.err, 1);
    chk("ovr_sen", bus.stream_en, 1);
    frame(1);
    frame(1);
    chk("ovr_done", bus.done, 1);
    chk("ovr_frames", bus.frames_done, 2);
    chk("ovr_err_kept", bus.err, 1);
    step();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("ovr_abortwins_err", bus.err, 1);
    chk("ovr_abortwins_busy", bus.busy, 0);
    start_acq(2'd1, 16'd2, 16'd1, 1'b1);
    chk("ovr_err_clr", bus.err, 0);
    chk("ovr_restart_busy", bus.busy, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // free-run with holdoff 3, start ignored while busy, abort mid-RUN
    start_acq(2'd0, 16'd0, 16'd3, 1'b1);
    step();
    step();
    chk("fr_arm3_sync", bus.ext_sync, 0);
    step();
    chk("fr_sync", bus.ext_sync, 1);
    step();
    chk("fr_run_sen", bus.stream_en, 1);
    frame(1);
    frame(1);
    chk("fr_frames", bus.frames_done, 2);
    chk("fr_no_done", bus.done, 0);
    chk("fr_still_run", bus.stream_en, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("fr_start_ign_frames", bus.frames_done, 2);
    chk("fr_start_ign_sen", bus.stream_en, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("fr_abort_sen", bus.stream_en, 0);
    chk("fr_abort_busy", bus.busy, 0);
    chk("fr_abort_done", bus.done, 0);
    chk("fr_abort_frames", bus.frames_done, 2);
    step();
    chk("fr_abort_done2", bus.done, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_frames", bus.frames_done, 2);
    chk("sa_sen", bus.stream_en, 0);

    // trigger already high on entry to WAIT_TRIG
    bus.trig_in = 1'b1;
    start_acq(2'd1, 16'd1, 16'd2, 1'b1);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hi_no_sync", bus.ext_sync, 0);
    end
    chk("hi_wait_busy", bus.busy, 1);
    bus.trig_in = 1'b0;
    step();
    chk("hi_fall_sync", bus.ext_sync, 0);
    bus.trig_in = 1'b1;
    step();
    chk("hi_rise_sync", bus.ext_sync, 1);
    step();
    frame(1);
    chk("hi_done", bus.done, 1);
    chk("hi_frames", bus.frames_done, 1);
    step();

    // reserved mode, falling edge, burst_len 0, clock-enable freeze in SYNC
    start_acq(2'd3, 16'd0, 16'd0, 1'b0);
    step();
    chk("fe_wait_sync", bus.ext_sync, 0);
    bus.trig_in = 1'b0;
    step();
    chk("fe_sync", bus.ext_sync, 1);
    ce = 1'b0;
    #1;
    chk("ce_sync_gated", bus.ext_sync, 0);
    step();
    step();
    chk("ce_hold_sync", bus.ext_sync, 0);
    chk("ce_hold_sen", bus.stream_en, 0);
    chk("ce_hold_busy", bus.busy, 1);
    ce = 1'b1;
    #1;
    chk("ce_resume_sync", bus.ext_sync, 1);
    step();
    chk("fe_run_sen", bus.stream_en, 1);
    frame(1);
    chk("fe_done", bus.done, 1);
    chk("fe_frames", bus.frames_done, 1);
    step();
    chk("fe_idle_busy", bus.busy, 0);
    chk("fe_idle_done", bus.done, 0);

`ifdef FRAME_SYNC_WATCHDOG_EN
    // watchdog: 16 cycles without a handshake in RUN
    start_acq(2'd0, 16'd0, 16'd0, 1'b1);
    step();
    step();
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b0;
    repeat (15) step();
    chk("wd_15_sen", bus.stream_en, 1);
    chk("wd_15_err", bus.err, 0);
    step();
    chk("wd_16_sen", bus.stream_en, 0);
    chk("wd_16_err", bus.err, 1);
    chk("wd_16_busy", bus.busy, 0);
    chk("wd_16_done", bus.done, 0);
    bus.mon_tvalid = 1'b0;
`endif

    // reset in the middle of RUN
    start_acq(2'd0, 16'd0, 16'd0, 1'b1);
    step();
    step();
    frame(1);
    chk("mr_frames_pre", bus.frames_done, 1);
    chk("mr_sen_pre", bus.stream_en, 1);
    reset_n = 1'b0;
    step();
    chk("mr_sen", bus.stream_en, 0);
    chk("mr_frames", bus.frames_done, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_err", bus.err, 0);
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
